// File: rtl/clk_burst_pkg.sv
// Shared types and default widths for the clock-burst controller.
// Pure declarations; no logic, no latency.
// Imported by clk_burst_ctrl and clk_phase_timer.
package clk_burst_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/clk_phase_timer.sv
// Phase timer: loadable DIV_W down-counter that parks at zero.
// Latency: value loaded at an edge is visible the next cycle; zero is combinational on the count.
// No backpressure; load always wins over decrement.
module clk_phase_timer
  import clk_burst_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             zero
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] count;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clk_burst_ctrl.sv
// Clock-burst controller: emits N periods of a 2H-cycle clock on clk_out, then pulses done.
// Latency: start sampled at edge k -> first LOW cycle k+1; done in cycle k+1+2HN.
// No backpressure: start is ignored unless IDLE; abort returns to IDLE without done.
module clk_burst_ctrl
  import clk_burst_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_cycles,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] half_lat;
  logic [CNT_W-1:0] num_lat;
  logic             accept;
  logic             tmr_load;
  logic [DIV_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             cnt_clr;
  logic             cnt_inc;

  clk_phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Next-state logic; abort has priority over start and over phase expiry.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = half_lat - ONE_D;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          cnt_clr = 1'b1;
          if (half_period == '0 || num_cycles == '0) begin
            state_nxt = DONE;
          end else begin
            accept    = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = half_period - ONE_D;
            state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_zero) begin
          tmr_load  = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_zero) begin
          if (cycle_count == num_lat) begin
            state_nxt = DONE;
          end else begin
            tmr_load  = 1'b1;
            state_nxt = LOW;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus latched burst configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_lat <= '0;
      num_lat  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        half_lat <= half_period;
        num_lat  <= num_cycles;
      end
    end
  end

  // Rising-edge counter; holds after the burst ends until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_count <= '0;
    end else if (cnt_inc) begin
      cycle_count <= cycle_count + ONE_C;
    end
  end

  // Outputs registered from the next state so clk_out is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out  <= 1'b0;
      rise_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      clk_out  <= (state_nxt == HIGH);
      rise_stb <= cnt_inc;
      busy     <= (state_nxt == LOW) || (state_nxt == HIGH);
      done     <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Testbench for clk_burst_ctrl: directed bursts plus random traffic against a cycle-offset model.
// Outputs are sampled on the falling edge; inputs change just after it.
// The model predicts each cycle's outputs from the offset since the accepted start.
module tb_clk_burst_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  half_period;
  logic [15:0] num_cycles;
  logic        clk_out;
  logic        rise_stb;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  // model: m_act = burst running, m_d = 1-based cycle offset inside the burst
  bit m_act  = 0;
  bit m_done = 0;
  int m_d    = 0;
  int m_h    = 0;
  int m_n    = 0;
  int m_cnt  = 0;

  clk_burst_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .half_period (half_period),
    .num_cycles  (num_cycles),
    .clk_out     (clk_out),
    .rise_stb    (rise_stb),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // rising edges emitted by burst offset d: rises sit at offsets H+1, 3H+1, ...
  function automatic int rises(input int d, input int h);
    if (d - 1 < h) return 0;
    return (d - 1 - h) / (2 * h) + 1;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit a, input int h, input int n);
    if (r) begin
      m_act = 0; m_done = 0; m_cnt = 0;
    end else if (m_act) begin
      if (a) begin
        m_act = 0; m_cnt = rises(m_d, m_h);
      end else if (m_d == 2 * m_h * m_n) begin
        m_act = 0; m_cnt = m_n; m_done = 1;
      end else begin
        m_d++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (s && !a) begin
      if (h == 0 || n == 0) begin
        m_done = 1; m_cnt = 0;
      end else begin
        m_act = 1; m_d = 1; m_h = h; m_n = n;
      end
    end
  endtask

  task automatic check_outputs();
    int e_clk, e_rise, e_cnt;
    if (m_act) begin
      e_clk  = ((m_d - 1) / m_h) % 2;
      e_rise = ((m_d - 1) % (2 * m_h) == m_h) ? 1 : 0;
      e_cnt  = rises(m_d, m_h);
    end else begin
      e_clk = 0; e_rise = 0; e_cnt = m_cnt;
    end
    check_val("clk_out", int'(clk_out), e_clk);
    check_val("rise_stb", int'(rise_stb), e_rise);
    check_val("busy", int'(busy), int'(m_act));
    check_val("done", int'(done), int'(m_done));
    check_val("cycle_count", int'(cycle_count), e_cnt);
  endtask

  // drive one cycle of inputs, advance model at the edge, check at the falling edge
  task automatic cyc(input bit r, input bit s, input bit a, input int h, input int n);
    rst = r; start = s; abort = a;
    half_period = 8'(h); num_cycles = 16'(n);
    @(posedge clk);
    model_step(r, s, a, h, n);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 9));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; half_period = '0; num_cycles = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 3, 3);
    idle(2);

    // reset mid-burst at busy cycle 7, then a fresh burst
    cyc(0, 1, 0, 3, 5);
    idle(6);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 2, 2);
    idle(10);

    // H=2 N=3 full waveform
    cyc(0, 1, 0, 2, 3);
    idle(14);

    // H=1 N=1
    cyc(0, 1, 0, 1, 1);
    idle(4);

    // degenerate configs
    cyc(0, 1, 0, 5, 0);
    idle(3);
    cyc(0, 1, 0, 0, 4);
    idle(3);

    // abort in cycle 20 of an H=4 N=10 burst
    cyc(0, 1, 0, 4, 10);
    idle(19);
    cyc(0, 0, 1, 0, 0);
    idle(3);

    // start together with abort while idle is ignored
    cyc(0, 1, 1, 2, 2);
    idle(3);

    // restart attempts during busy and during done are ignored
    cyc(0, 1, 0, 2, 3);
    idle(3);
    cyc(0, 1, 0, 5, 1);
    idle(8);
    cyc(0, 1, 0, 7, 7);
    idle(6);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, s, a;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 39) == 0);
      cyc(r, s, a, $urandom_range(0, 4), $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
